ring_scan_driver: RTL and testbench
===================================

Name: ring_scan_driver

Overview:
- Downstream consumer of the 4-bit one-hot ring counter: uses its rotating phase to time-multiplex a 4-digit common-anode seven-segment display.
- Double-buffers the 16-bit display word; new data is applied only at frame boundaries.
- Continuously checks that the incoming phase is legal (one-hot, correct successor every cycle); blanks the display and records faults when it is not.

Parameters:
- SYNC_LEN, 2, consecutive legal phase steps required in SYNC before entering RUN (range 1..15).
- FCNT_W, 8, width of the saturating fault counter.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- phase_in  input  [0:3]  one-hot phase from ring counter; bit i high selects digit i; legal successor of bit i is bit (i+1) mod 4.
- data_in  input  16  display word; nibble i = data_in[4i+3:4i] shown on digit i.
- data_load  input  1  when high, data_in is captured into the pending buffer.
- clear_fault  input  1  leaves FAULT and clears fault_flag.
- anode_n  output  4  active-low digit enables, registered.
- seg_n  output  7  active-low segments {g,f,e,d,c,b,a}, registered hex decode.
- locked  output  1  high while the FSM is in RUN.
- fault_flag  output  1  sticky; set on entry to FAULT.
- fault_cnt  output  FCNT_W  number of FAULT entries, saturating.

Behaviour:
- Reset values:
  - anode_n=4'hF, seg_n=7'h7F, locked=0, fault_flag=0, fault_cnt=0.
  - Pending and active buffers = 16'h0000, pend_valid=0, FSM=SYNC, sync counter=0, prev_phase=4'b0000.
- Legality checks:
  - legal = phase_in has exactly one bit set.
  - step_ok = legal AND prev_phase legal AND phase_in equals prev_phase rotated to the successor.
  - prev_phase <= phase_in every cycle.
- FSM states and transitions:
  - SYNC: step_ok increments the sync counter, otherwise the counter returns to 0. When the count reaches SYNC_LEN, go to RUN on the next edge. Outputs blanked.
  - RUN: locked=1. If step_ok=0, go to FAULT on the next edge, set fault_flag, and increment fault_cnt (held at all-ones).
  - FAULT: outputs blanked, locked=0. Stays in FAULT until clear_fault=1. Then go to SYNC, clear fault_flag, reset the sync counter. fault_cnt is not cleared.
- Display path:
  - One-cycle latency: anode_n/seg_n at edge t+1 reflect phase_in and the active buffer at edge t.
  - In RUN: anode_n[i] = ~phase_in[i], and seg_n = hex decode of the active nibble i.
  - Hex decode: standard 0-F, active low. Example: 0 -> 7'h40, 1 -> 7'h79, 8 -> 7'h00, F -> 7'h0E.
  - Blank in SYNC, FAULT, and on the cycle in which step_ok=0 in RUN: anode_n=F, seg_n=7F. An illegal phase is never driven onto the display.
- Buffering:
  - data_load=1 writes the pending buffer and sets pend_valid. The last load wins.
  - Frame boundary = cycle with phase_in[0]=1 and legal. If pend_valid at a boundary, active <= pending and pend_valid clears.
  - If data_load and a boundary occur in the same cycle, the old pending value transfers, the new value stays pending, and pend_valid remains 1.
  - The transfer happens at a boundary in any FSM state, so data is current on lock.
  - The boundary digit uses the old active value in that same cycle; the new value is visible from the next digit.
- Simultaneous events:
  - clear_fault outside FAULT is ignored.
  - A phase fault in the same cycle as a RUN entry is evaluated next cycle.
  - rst has priority over all inputs. rst asserted mid-frame blanks outputs on the next edge and discards pending data.

Test Plan:
- Reset, then drive legal ring sequence 0001->1000->0100->0010 (bit3,0,1,2) every cycle with SYNC_LEN=2 -> locked rises on the 3rd edge after the first legal phase; outputs blank until RUN.
- In RUN, load data_in=16'h8F10 before a phase[0] boundary -> from the following digit onward: digit0 shows seg_n=7'h40, digit1 7'h79, digit2 7'h0E, digit3 7'h00. anode_n is the complement of the previous cycle's phase_in.
- In RUN, inject phase_in=4'b0110 for one cycle -> blank that cycle; FAULT next edge; fault_flag=1, fault_cnt=1, locked=0; outputs stay blank with legal phases.
- In RUN, repeat the same legal phase two cycles (stall) -> FAULT as above. Pulse clear_fault -> SYNC, then RUN after SYNC_LEN legal steps; fault_cnt stays 1.
- Force 256 fault/clear cycles with FCNT_W=8 -> fault_cnt holds 8'hFF.
- data_load with 16'h1111 then 16'h2222 on the boundary cycle -> 1111 becomes active; 2222 becomes active at the next boundary. Assert rst mid-frame -> all outputs at reset values next edge.

Source files
------------

// File: rtl/ring_scan_driver.sv
// Seven-segment scan driver timed by a one-hot ring phase.
// Checks every phase step, double-buffers the display word, and blanks the
// display whenever the phase sequence cannot be trusted.
module ring_scan_driver #(
  parameter int unsigned SYNC_LEN = 2,
  parameter int unsigned FCNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [0:3]        phase_in,
  input  logic [15:0]       data_in,
  input  logic              data_load,
  input  logic              clear_fault,
  output logic [3:0]        anode_n,
  output logic [6:0]        seg_n,
  output logic              locked,
  output logic              fault_flag,
  output logic [FCNT_W-1:0] fault_cnt
);

  localparam int unsigned SCNT_W = 4;

  typedef enum logic [1:0] {ST_SYNC, ST_RUN, ST_FAULT} state_t;

  state_t            state_q, state_d;
  logic [SCNT_W-1:0] sync_cnt_q, sync_cnt_d;
  logic [0:3]        prev_phase;
  logic [0:3]        succ;
  logic [15:0]       pend_buf, active_buf;
  logic              pend_valid;
  logic              legal, step_ok, boundary, show;
  logic              fault_flag_d;
  logic [FCNT_W-1:0] fault_cnt_d;
  logic [1:0]        dig;
  logic [3:0]        nib;
  logic [6:0]        seg_dec;
  logic [3:0]        anode_d;

  // Phase legality: one-hot, and exactly the successor of last cycle's phase
  always_comb begin
    succ     = {prev_phase[3], prev_phase[0], prev_phase[1], prev_phase[2]};
    legal    = $onehot(phase_in);
    step_ok  = legal && $onehot(prev_phase) && (phase_in == succ);
    boundary = legal && phase_in[0];
  end

  // Digit select, nibble pick, anode pattern and active-low hex decode
  always_comb begin
    dig = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (phase_in[i]) dig = 2'(i);
      anode_d[i] = ~phase_in[i];
    end
    case (dig)
      2'd0:    nib = active_buf[3:0];
      2'd1:    nib = active_buf[7:4];
      2'd2:    nib = active_buf[11:8];
      default: nib = active_buf[15:12];
    endcase
    case (nib)
      4'h0: seg_dec = 7'h40;
      4'h1: seg_dec = 7'h79;
      4'h2: seg_dec = 7'h24;
      4'h3: seg_dec = 7'h30;
      4'h4: seg_dec = 7'h19;
      4'h5: seg_dec = 7'h12;
      4'h6: seg_dec = 7'h02;
      4'h7: seg_dec = 7'h78;
      4'h8: seg_dec = 7'h00;
      4'h9: seg_dec = 7'h10;
      4'hA: seg_dec = 7'h08;
      4'hB: seg_dec = 7'h03;
      4'hC: seg_dec = 7'h46;
      4'hD: seg_dec = 7'h21;
      4'hE: seg_dec = 7'h06;
      default: seg_dec = 7'h0E;
    endcase
  end

  // Next-state, sync counting, fault bookkeeping and display enable
  always_comb begin
    state_d      = state_q;
    sync_cnt_d   = '0;
    fault_flag_d = fault_flag;
    fault_cnt_d  = fault_cnt;
    show         = 1'b0;
    case (state_q)
      ST_SYNC: begin
        if (step_ok) begin
          if (sync_cnt_q == SCNT_W'(SYNC_LEN - 1)) state_d = ST_RUN;
          else sync_cnt_d = sync_cnt_q + SCNT_W'(1);
        end
      end
      ST_RUN: begin
        if (step_ok) begin
          show = 1'b1;
        end else begin
          state_d      = ST_FAULT;
          fault_flag_d = 1'b1;
          if (fault_cnt != {FCNT_W{1'b1}}) fault_cnt_d = fault_cnt + FCNT_W'(1);
        end
      end
      ST_FAULT: begin
        if (clear_fault) begin
          state_d      = ST_SYNC;
          fault_flag_d = 1'b0;
        end
      end
      default: state_d = ST_SYNC;
    endcase
  end

  // State, status and display registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_SYNC;
      sync_cnt_q <= '0;
      prev_phase <= 4'b0000;
      locked     <= 1'b0;
      fault_flag <= 1'b0;
      fault_cnt  <= '0;
      anode_n    <= 4'hF;
      seg_n      <= 7'h7F;
    end else begin
      state_q    <= state_d;
      sync_cnt_q <= sync_cnt_d;
      prev_phase <= phase_in;
      locked     <= (state_d == ST_RUN);
      fault_flag <= fault_flag_d;
      fault_cnt  <= fault_cnt_d;
      anode_n    <= show ? anode_d : 4'hF;
      seg_n      <= show ? seg_dec : 7'h7F;
    end
  end

  // Double buffer: pending word moves to active only on a legal frame boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_buf   <= '0;
      active_buf <= '0;
      pend_valid <= 1'b0;
    end else begin
      if (boundary && pend_valid) active_buf <= pend_buf;
      if (data_load) begin
        pend_buf   <= data_in;
        pend_valid <= 1'b1;
      end else if (boundary) begin
        pend_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ring_scan_driver.sv
// Bench for ring_scan_driver: directed vector table, hand-built corner
// sequences and random phase traffic against a behavioural model.
module tb_ring_scan_driver;

  localparam int unsigned SYNC_LEN = 2;
  localparam int unsigned FCNT_W   = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [0:3]        phase_in;
  logic [15:0]       data_in;
  logic              data_load;
  logic              clear_fault;
  logic [3:0]        anode_n;
  logic [6:0]        seg_n;
  logic              locked;
  logic              fault_flag;
  logic [FCNT_W-1:0] fault_cnt;

  ring_scan_driver #(.SYNC_LEN(SYNC_LEN), .FCNT_W(FCNT_W)) dut (
    .clk(clk), .rst(rst), .phase_in(phase_in), .data_in(data_in),
    .data_load(data_load), .clear_fault(clear_fault), .anode_n(anode_n),
    .seg_n(seg_n), .locked(locked), .fault_flag(fault_flag), .fault_cnt(fault_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [6:0] hexlut [16];

  // model state: mode 0=sync 1=run 2=fault
  int          m_mode, m_streak, m_prev, m_cnt;
  logic [15:0] m_pend, m_active;
  bit          m_pv, m_flag;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  bit          e_lock;

  typedef struct {
    logic [0:3]  ph;
    logic        ld;
    logic [15:0] d;
    logic        rs;
    logic [3:0]  an;
    logic [6:0]  sg;
    logic        lk;
  } vec_t;
  vec_t tv [11];

  int cur;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [0:3] p);
    int n = 0;
    int k = -1;
    for (int i = 0; i < 4; i++) if (p[i] === 1'b1) begin n++; k = i; end
    return (n == 1) ? k : -1;
  endfunction

  function automatic logic [0:3] ph_of(input int i);
    logic [0:3] p = 4'b0000;
    p[i] = 1'b1;
    return p;
  endfunction

  task automatic model_edge();
    int  i;
    bit  ok;
    int  nibv;
    if (rst) begin
      m_mode = 0; m_streak = 0; m_prev = -1; m_cnt = 0;
      m_pend = 16'h0; m_active = 16'h0; m_pv = 0; m_flag = 0;
      e_an = 4'hF; e_seg = 7'h7F; e_lock = 0;
      return;
    end
    i  = idx_of(phase_in);
    ok = (i >= 0) && (m_prev >= 0) && (i == (m_prev + 1) % 4);
    if (m_mode == 1 && ok) begin
      e_an    = 4'hF;
      e_an[i] = 1'b0;
      nibv    = int'((m_active >> (4 * i)) & 16'hF);
      e_seg   = hexlut[nibv];
    end else begin
      e_an = 4'hF; e_seg = 7'h7F;
    end
    case (m_mode)
      0: begin
        m_streak = ok ? m_streak + 1 : 0;
        if (m_streak == SYNC_LEN) begin m_mode = 1; m_streak = 0; end
      end
      1: if (!ok) begin
        m_mode = 2; m_flag = 1;
        m_cnt  = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
      end
      default: if (clear_fault) begin m_mode = 0; m_flag = 0; m_streak = 0; end
    endcase
    if (i == 0 && m_pv) begin m_active = m_pend; m_pv = 0; end
    if (data_load) begin m_pend = data_in; m_pv = 1; end
    m_prev = i;
    e_lock = (m_mode == 1);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("model_anode", 16'(anode_n), 16'(e_an));
    chk("model_seg", 16'(seg_n), 16'(e_seg));
    chk("model_locked", 16'(locked), 16'(e_lock));
    chk("model_flag", 16'(fault_flag), 16'(m_flag));
    chk("model_cnt", 16'(fault_cnt), 16'(m_cnt));
  endtask

  task automatic drive(input logic [0:3] ph, input logic ld, input logic [15:0] d,
                       input logic clr, input logic r);
    phase_in = ph; data_load = ld; data_in = d; clear_fault = clr; rst = r;
    step();
  endtask

  task automatic expect_out(input string nm, input logic [3:0] an, input logic [6:0] sg,
                            input logic lk, input logic fl, input logic [7:0] cn);
    chk({nm, "_anode"}, 16'(anode_n), 16'(an));
    chk({nm, "_seg"}, 16'(seg_n), 16'(sg));
    chk({nm, "_locked"}, 16'(locked), 16'(lk));
    chk({nm, "_flag"}, 16'(fault_flag), 16'(fl));
    chk({nm, "_cnt"}, 16'(fault_cnt), 16'(cn));
  endtask

  initial begin
    hexlut = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    tv[0]  = '{4'b0000, 1'b0, 16'h0000, 1'b1, 4'hF, 7'h7F, 1'b0};
    tv[1]  = '{4'b0001, 1'b0, 16'h0000, 1'b0, 4'hF, 7'h7F, 1'b0};
    tv[2]  = '{4'b1000, 1'b0, 16'h0000, 1'b0, 4'hF, 7'h7F, 1'b0};
    tv[3]  = '{4'b0100, 1'b0, 16'h0000, 1'b0, 4'hF, 7'h7F, 1'b1};
    tv[4]  = '{4'b0010, 1'b1, 16'h8F10, 1'b0, 4'hB, 7'h40, 1'b1};
    tv[5]  = '{4'b0001, 1'b0, 16'h0000, 1'b0, 4'h7, 7'h40, 1'b1};
    tv[6]  = '{4'b1000, 1'b0, 16'h0000, 1'b0, 4'hE, 7'h40, 1'b1};
    tv[7]  = '{4'b0100, 1'b0, 16'h0000, 1'b0, 4'hD, 7'h79, 1'b1};
    tv[8]  = '{4'b0010, 1'b0, 16'h0000, 1'b0, 4'hB, 7'h0E, 1'b1};
    tv[9]  = '{4'b0001, 1'b0, 16'h0000, 1'b0, 4'h7, 7'h00, 1'b1};
    tv[10] = '{4'b1000, 1'b0, 16'h0000, 1'b0, 4'hE, 7'h40, 1'b1};

    rst = 1'b1; phase_in = 4'b0000; data_in = 16'h0; data_load = 1'b0; clear_fault = 1'b0;

    // lock-up and first frame of 8F10
    for (int k = 0; k < 11; k++) begin
      drive(tv[k].ph, tv[k].ld, tv[k].d, 1'b0, tv[k].rs);
      chk($sformatf("vec%0d_anode", k), 16'(anode_n), 16'(tv[k].an));
      chk($sformatf("vec%0d_seg", k), 16'(seg_n), 16'(tv[k].sg));
      chk($sformatf("vec%0d_locked", k), 16'(locked), 16'(tv[k].lk));
      if (k == 0) chk("reset_cnt", 16'(fault_cnt), 16'h0);
    end

    // non-one-hot phase in RUN
    drive(4'b0110, 0, 16'h0, 0, 0);  expect_out("glitch", 4'hF, 7'h7F, 0, 1, 8'd1);
    drive(4'b0100, 0, 16'h0, 0, 0);  expect_out("fault_hold1", 4'hF, 7'h7F, 0, 1, 8'd1);
    drive(4'b0010, 0, 16'h0, 0, 0);  expect_out("fault_hold2", 4'hF, 7'h7F, 0, 1, 8'd1);
    drive(4'b0001, 0, 16'h0, 0, 0);  expect_out("fault_hold3", 4'hF, 7'h7F, 0, 1, 8'd1);
    // clear and relock, then stall
    drive(4'b1000, 0, 16'h0, 1, 0);  expect_out("clear", 4'hF, 7'h7F, 0, 0, 8'd1);
    drive(4'b0100, 0, 16'h0, 0, 0);  expect_out("resync1", 4'hF, 7'h7F, 0, 0, 8'd1);
    drive(4'b0010, 0, 16'h0, 0, 0);  expect_out("relock", 4'hF, 7'h7F, 1, 0, 8'd1);
    drive(4'b0001, 0, 16'h0, 0, 0);  expect_out("run_dig3", 4'h7, 7'h00, 1, 0, 8'd1);
    drive(4'b0001, 0, 16'h0, 0, 0);  expect_out("stall", 4'hF, 7'h7F, 0, 1, 8'd2);

    // fault counter saturation
    cur = 3;
    for (int n = 0; n < 256; n++) begin
      cur = (cur + 1) % 4; drive(ph_of(cur), 0, 16'h0, 1, 0);
      cur = (cur + 1) % 4; drive(ph_of(cur), 0, 16'h0, 0, 0);
      cur = (cur + 1) % 4; drive(ph_of(cur), 0, 16'h0, 0, 0);
      drive(4'b0000, 0, 16'h0, 0, 0);
    end
    expect_out("saturate", 4'hF, 7'h7F, 0, 1, 8'hFF);

    // load on the boundary cycle
    drive(4'b1000, 0, 16'h0, 1, 0);
    drive(4'b0100, 0, 16'h0, 0, 0);
    drive(4'b0010, 0, 16'h0, 0, 0);     chk("dl_locked", 16'(locked), 16'h1);
    drive(4'b0001, 1, 16'h1111, 0, 0);  chk("dl_pre", 16'(seg_n), 16'h00);
    drive(4'b1000, 1, 16'h2222, 0, 0);  chk("dl_bnd_old", 16'(seg_n), 16'h40);
    drive(4'b0100, 0, 16'h0, 0, 0);     chk("dl_first_d1", 16'(seg_n), 16'h79);
    drive(4'b0010, 0, 16'h0, 0, 0);     chk("dl_first_d2", 16'(seg_n), 16'h79);
    drive(4'b0001, 0, 16'h0, 0, 0);     chk("dl_first_d3", 16'(seg_n), 16'h79);
    drive(4'b1000, 0, 16'h0, 0, 0);     chk("dl_bnd2_old", 16'(seg_n), 16'h79);
    drive(4'b0100, 0, 16'h0, 0, 0);     chk("dl_second_d1", 16'(seg_n), 16'h24);

    // reset mid-frame discards pending data
    drive(4'b0010, 1, 16'h3333, 0, 0);  chk("pre_rst", 16'(seg_n), 16'h24);
    drive(4'b0001, 0, 16'h0, 0, 1);     expect_out("mid_rst", 4'hF, 7'h7F, 0, 0, 8'd0);
    drive(4'b1000, 0, 16'h0, 0, 0);
    drive(4'b0100, 0, 16'h0, 0, 0);
    drive(4'b0010, 0, 16'h0, 0, 0);     chk("rst_relock", 16'(locked), 16'h1);
    drive(4'b0001, 0, 16'h0, 0, 0);     chk("rst_d3", 16'(seg_n), 16'h40);
    drive(4'b1000, 0, 16'h0, 0, 0);     chk("rst_d0", 16'(seg_n), 16'h40);
    drive(4'b0100, 0, 16'h0, 0, 0);     chk("rst_discard", 16'(seg_n), 16'h40);

    // random traffic against the model
    cur = 1;
    for (int n = 0; n < 3000; n++) begin
      logic [0:3] ph;
      int r = int'($urandom_range(0, 99));
      if (r < 6) ph = 4'($urandom);
      else if (r < 10) ph = ph_of(cur);
      else begin cur = (cur + 1) % 4; ph = ph_of(cur); end
      drive(ph, ($urandom_range(0, 7) == 0), 16'($urandom),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 299) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
